control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter: DATA_WIDTH, 8, width of bus and instruction register.
REQ-002 One clock and one reset: reset is asynchronous and active-low; clock is i_CLOCK and reset is i_CLEAR_n.
REQ-003 i_CLOCK  in  1  CPU clock (gated o_CLOCK of the clock module); all state updates on its rising edge.
REQ-004 i_CLEAR_n  in  1  asynchronous active-low reset.
REQ-005 i_BUS  in  DATA_WIDTH  shared bus value, sampled when o_II_n is low.
REQ-006 i_FLAG_C, i_FLAG_Z  in  1 each  carry/zero flags from the flags register.
REQ-007 o_CO_n, o_J_n, o_MI_n, o_RO_n, o_RI_n, o_II_n, o_IO_n, o_AI_n, o_AO_n, o_BI_n, o_EO_n  out  1 each  active-low control lines (PC out, jump, MAR in, RAM out, RAM in, IR in, IR out, A in, A out, B in, ALU out).
REQ-008 o_CE, o_SU, o_OI, o_HLT  out  1 each  active-high count enable, subtract, output-register read, halt.
REQ-009 o_OPERAND  out  DATA_WIDTH  {zeros, IR[3:0]}; valid for bus use only while o_IO_n is low.
REQ-010 o_STEP  out  3  current microstep, for debug display.

Function
REQ-011 State: 3-bit step counter (0..4), DATA_WIDTH instruction register IR, 1-bit halted flag.
REQ-012 Control outputs are combinational from (step, IR[7:4], flags, halted); all unlisted lines inactive.
REQ-013 Fetch, every opcode: step 0 = CO_n, MI_n; step 1 = RO_n, II_n, CE.
REQ-014 IR loads i_BUS on the rising edge ending step 1; this is the only IR write.
REQ-015 Opcodes (IR[7:4]), steps 2..: NOP 0000 none; LDA 0001 IO_n+MI_n, RO_n+AI_n; ADD 0010 IO_n+MI_n, RO_n+BI_n, EO_n+AI_n; SUB 0011 as ADD plus SU in the EO_n step; STA 0100 IO_n+MI_n, AO_n+RI_n; LDI 0101 IO_n+AI_n; JMP 0110 IO_n+J_n; JC 0111 IO_n+J_n if i_FLAG_C else none; JZ 1000 IO_n+J_n if i_FLAG_Z else none; OUT 1110 AO_n+OI; HLT 1111 HLT.
REQ-016 Undefined opcodes decode as NOP.
REQ-017 Instruction length (steps): NOP 2, LDA 4, ADD 5, SUB 5, STA 4, LDI 3, JMP 3, JC 3, JZ 3, OUT 3, HLT 3.
REQ-018 Step advances by 1 each edge; on the edge ending the last step of the current opcode it wraps to 0; a step never exceeds 4.
REQ-019 JC/JZ sample flags combinationally during step 2; a flag change within step 2 changes J_n in that cycle.
REQ-020 On the edge ending HLT step 2, halted is set; while halted: step held at 2, IR held, o_HLT=1, all other control lines inactive.
REQ-021 Only reset clears halted.
REQ-022 o_SU is 0 in every step except SUB step 4.
REQ-023 At no time may more than one bus driver (CO_n, RO_n, IO_n, AO_n, EO_n) be low.

Reset
REQ-024 While i_CLEAR_n is low: step=0, IR=0, halted=0, all active-low outputs 1, all active-high outputs 0, o_STEP=0, regardless of i_CLOCK.
REQ-025 Reset asserted mid-instruction aborts it immediately (same cycle, asynchronously).
REQ-026 First rising edge after release: the step-0 fetch word (CO_n, MI_n low) is already present before that edge, and the step advances to 1 on it.

Verification
REQ-027 Reset, release, i_BUS=0x1E during step 1 -> steps 0,1,2,3 then 0; IO_n+MI_n at step 2 with o_OPERAND=0x0E; RO_n+AI_n at step 3.
REQ-028 IR=0x3F (SUB) -> step 4 shows EO_n=0, AI_n=0, SU=1; SU=0 in steps 0-3; next edge gives step 0.
REQ-029 JC 0x75 with i_FLAG_C=0 then a repeat with i_FLAG_C=1 -> J_n stays 1 in the first pass; J_n=0 with o_OPERAND=0x05 at step 2 in the second.
REQ-030 IR=0xF0 (HLT) -> o_HLT=1 from step 2 onward; 10 further edges keep o_STEP=2 and IR=0xF0; reset clears HLT.
REQ-031 Reset pulse asserted asynchronously mid-ADD step 3 -> outputs go inactive without a clock edge; after release, fetch restarts at step 0 with IR=0.
REQ-032 Random opcode stream (incl. 0x9x-0xDx) with scoreboard -> undefined opcodes take 2 steps; bus-driver exclusivity (REQ-023) holds every cycle.

Source files
------------

// File: rtl/control_sequencer.sv
// Microcode sequencer for the 8-bit breadboard CPU: fetch/execute step
// counter, instruction register and halt latch driving the control lines.
module control_sequencer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_CLOCK,
    input  logic                  i_CLEAR_n,
    input  logic [DATA_WIDTH-1:0] i_BUS,
    input  logic                  i_FLAG_C,
    input  logic                  i_FLAG_Z,
    output logic                  o_CO_n,
    output logic                  o_J_n,
    output logic                  o_MI_n,
    output logic                  o_RO_n,
    output logic                  o_RI_n,
    output logic                  o_II_n,
    output logic                  o_IO_n,
    output logic                  o_AI_n,
    output logic                  o_AO_n,
    output logic                  o_BI_n,
    output logic                  o_EO_n,
    output logic                  o_CE,
    output logic                  o_SU,
    output logic                  o_OI,
    output logic                  o_HLT,
    output logic [DATA_WIDTH-1:0] o_OPERAND,
    output logic [2:0]            o_STEP
);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } step_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    step_t                 step;
    step_t                 step_nxt;
    logic [DATA_WIDTH-1:0] ir;
    logic                  ir_load;
    logic                  halted;
    logic                  halted_nxt;
    logic [3:0]            op;

    logic co, j, mi, ro, ri, ii, io, ai, ao, bi, eo;
    logic ce, su, oi, hlt;

    assign op = ir[7:4];

    function automatic step_t last_step(input logic [3:0] opc);
        case (opc)
            OP_LDA, OP_STA: last_step = S3;
            OP_ADD, OP_SUB: last_step = S4;
            OP_LDI, OP_JMP, OP_JC, OP_JZ,
            OP_OUT, OP_HLT: last_step = S2;
            default:        last_step = S1;
        endcase
    endfunction

    always_ff @(posedge i_CLOCK or negedge i_CLEAR_n) begin
        if (!i_CLEAR_n) begin
            step   <= S0;
            ir     <= '0;
            halted <= 1'b0;
        end else begin
            step   <= step_nxt;
            halted <= halted_nxt;
            if (ir_load) begin
                ir <= i_BUS;
            end
        end
    end

    // At step 1 the IR is not loaded yet, so the length comes from the bus.
    always_comb begin
        step_nxt   = step;
        halted_nxt = halted;
        ir_load    = 1'b0;
        if (!halted) begin
            case (step)
                S0: step_nxt = S1;
                S1: begin
                    ir_load  = 1'b1;
                    step_nxt = (last_step(i_BUS[7:4]) == S1) ? S0 : S2;
                end
                default: begin
                    if (step >= last_step(op)) begin
                        if (op == OP_HLT) begin
                            halted_nxt = 1'b1;
                        end else begin
                            step_nxt = S0;
                        end
                    end else begin
                        step_nxt = step_t'(step + 3'd1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        co  = 1'b0;
        j   = 1'b0;
        mi  = 1'b0;
        ro  = 1'b0;
        ri  = 1'b0;
        ii  = 1'b0;
        io  = 1'b0;
        ai  = 1'b0;
        ao  = 1'b0;
        bi  = 1'b0;
        eo  = 1'b0;
        ce  = 1'b0;
        su  = 1'b0;
        oi  = 1'b0;
        hlt = 1'b0;
        if (i_CLEAR_n && halted) begin
            hlt = 1'b1;
        end else if (i_CLEAR_n) begin
            case (step)
                S0: begin
                    co = 1'b1;
                    mi = 1'b1;
                end
                S1: begin
                    ro = 1'b1;
                    ii = 1'b1;
                    ce = 1'b1;
                end
                S2: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            io = 1'b1;
                            mi = 1'b1;
                        end
                        OP_LDI: begin
                            io = 1'b1;
                            ai = 1'b1;
                        end
                        OP_JMP: begin
                            io = 1'b1;
                            j  = 1'b1;
                        end
                        OP_JC: begin
                            io = i_FLAG_C;
                            j  = i_FLAG_C;
                        end
                        OP_JZ: begin
                            io = i_FLAG_Z;
                            j  = i_FLAG_Z;
                        end
                        OP_OUT: begin
                            ao = 1'b1;
                            oi = 1'b1;
                        end
                        OP_HLT:  hlt = 1'b1;
                        default: ;
                    endcase
                end
                S3: begin
                    case (op)
                        OP_LDA: begin
                            ro = 1'b1;
                            ai = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ro = 1'b1;
                            bi = 1'b1;
                        end
                        OP_STA: begin
                            ao = 1'b1;
                            ri = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S4: begin
                    if (op == OP_ADD || op == OP_SUB) begin
                        eo = 1'b1;
                        ai = 1'b1;
                        su = (op == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_CO_n    = ~co;
    assign o_J_n     = ~j;
    assign o_MI_n    = ~mi;
    assign o_RO_n    = ~ro;
    assign o_RI_n    = ~ri;
    assign o_II_n    = ~ii;
    assign o_IO_n    = ~io;
    assign o_AI_n    = ~ai;
    assign o_AO_n    = ~ao;
    assign o_BI_n    = ~bi;
    assign o_EO_n    = ~eo;
    assign o_CE      = ce;
    assign o_SU      = su;
    assign o_OI      = oi;
    assign o_HLT     = hlt;
    assign o_OPERAND = {{(DATA_WIDTH-4){1'b0}}, ir[3:0]};
    assign o_STEP    = step;

endmodule
